// File: rtl/sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 1;

    // Number of input vectors for an n-input function.
    function automatic int num_vectors(input int n);
        return 1 << n;
    endfunction

    localparam int NVEC = num_vectors(DEF_N_IN);

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks a combinational function's inputs through every vector and captures its truth table.
// Optional build macro EXPECT_CHECK_EN adds expected-table comparison (mismatch / first_bad).
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [N_IN-1:0]                vec_out,
    input  logic                           res_in,
    output logic                           busy,
    output logic                           done,
`ifdef EXPECT_CHECK_EN
    input  logic [num_vectors(N_IN)-1:0]   expect_in,
    output logic                           mismatch,
    output logic [N_IN-1:0]                first_bad,
`endif
    output logic [num_vectors(N_IN)-1:0]   table_out,
    output logic [N_IN:0]                  ones_cnt
);

    localparam int NV = num_vectors(N_IN);
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);
    localparam logic [WW-1:0]   WAIT_END = WW'(SETTLE - 1);

    state_t          state_reg;
    logic [N_IN-1:0] idx_reg;
    logic [WW-1:0]   wait_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [NV-1:0]   table_reg;
    logic [N_IN:0]   ones_reg;
    logic [NV-1:0]   sel;
    logic [NV-1:0]   table_next;

`ifdef EXPECT_CHECK_EN
    logic            mismatch_reg;
    logic [N_IN-1:0] first_bad_reg;
`endif

    // One-hot decode of the current vector index selects the table bit to capture.
    generate
        for (genvar gi = 0; gi < NV; gi++) begin : g_sel
            assign sel[gi] = (idx_reg == N_IN'(gi));
        end
    endgenerate

    assign table_next = (table_reg & ~sel) | (sel & {NV{res_in}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            wait_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            table_reg <= '0;
            ones_reg  <= '0;
`ifdef EXPECT_CHECK_EN
            mismatch_reg  <= 1'b0;
            first_bad_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= WAIT;
                        idx_reg   <= '0;
                        wait_reg  <= '0;
                        table_reg <= '0;
                        ones_reg  <= '0;
                        busy_reg  <= 1'b1;
`ifdef EXPECT_CHECK_EN
                        mismatch_reg  <= 1'b0;
                        first_bad_reg <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (wait_reg == WAIT_END) begin
                        state_reg <= SAMPLE;
                    end else begin
                        wait_reg <= wait_reg + WW'(1);
                    end
                end
                SAMPLE: begin
                    table_reg <= table_next;
                    ones_reg  <= ones_reg + (N_IN+1)'(res_in);
`ifdef EXPECT_CHECK_EN
                    // Only the first disagreeing vector is latched.
                    if ((res_in != expect_in[idx_reg]) && !mismatch_reg) begin
                        mismatch_reg  <= 1'b1;
                        first_bad_reg <= idx_reg;
                    end
`endif
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= FINISH;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= WAIT;
                        idx_reg   <= idx_reg + N_IN'(1);
                        wait_reg  <= '0;
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign vec_out   = idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign table_out = table_reg;
    assign ones_cnt  = ones_reg;

`ifdef EXPECT_CHECK_EN
    assign mismatch  = mismatch_reg;
    assign first_bad = first_bad_reg;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a SETTLE=1 instance and a SETTLE=3 instance.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic [3:0]  vec, vec3;
    logic        res, res3;
    logic        busy, busy3, done, done3;
    logic [15:0] table_o, table3;
    logic [4:0]  ones, ones3;
    logic [15:0] fn_tbl;
    logic [15:0] ref_tbl;
`ifdef EXPECT_CHECK_EN
    logic [15:0] expect_v;
    logic        mismatch, mismatch3;
    logic [3:0]  first_bad, first_bad3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec), .res_in(res),
        .busy(busy), .done(done),
`ifdef EXPECT_CHECK_EN
        .expect_in(expect_v), .mismatch(mismatch), .first_bad(first_bad),
`endif
        .table_out(table_o), .ones_cnt(ones)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .res_in(res3),
        .busy(busy3), .done(done3),
`ifdef EXPECT_CHECK_EN
        .expect_in(expect_v), .mismatch(mismatch3), .first_bad(first_bad3),
`endif
        .table_out(table3), .ones_cnt(ones3)
    );

    // Function under sweep: a lookup table chosen per test.
    assign res = fn_tbl[vec];

    // Second instance sees a result registered one cycle behind its vector.
    always_ff @(posedge clk) res3 <= ref_tbl[vec3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at #1 after an edge. Returns the cycle number of done (start cycle = 1).
    task automatic sweep(input string tag, input logic [15:0] tbl, input logic [15:0] exp_tbl,
                         input logic [4:0] exp_ones, input bit pulse_extra);
        int n;
        int dones;
        fn_tbl = tbl;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        dones = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = pulse_extra && (n == 5 || n == 20);
            if (done) dones++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, 33);
        check({tag, "_table"}, table_o, exp_tbl);
        check({tag, "_ones"}, ones, exp_ones);
        if (pulse_extra) begin
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            check({tag, "_done_pulses"}, dones, 1);
            check({tag, "_idle_after"}, busy, 0);
            check({tag, "_table_hold"}, table_o, exp_tbl);
        end
        $display("sweep %s: cycles=%0d table=%h ones=%0d", tag, n, table_o, ones);
    endtask

    initial begin
        int n;
        int run_len;
        int hold_bad;
        logic [3:0] prev;
        bit found;

        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        fn_tbl = 16'h2C80; ref_tbl = 16'h2C80;
`ifdef EXPECT_CHECK_EN
        expect_v = 16'h2C80;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec", vec, 0);
        check("rst_table", table_o, 0);
        check("rst_ones", ones, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: reference minterms 7,10,11,13
        sweep("ref", 16'h2C80, 16'h2C80, 5'd4, 1'b0);
`ifdef EXPECT_CHECK_EN
        check("ref_mismatch", mismatch, 0);
`endif

        // start held high: FINISH -> IDLE (one cycle) -> WAIT with cleared results
        start = 1'b1;
        n = 0;
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        check("held_done_seen", done, 1);
        @(posedge clk); #1;
        check("held_idle_gap", busy, 0);
        @(posedge clk); #1;
        check("held_restart_busy", busy, 1);
        check("held_restart_clear", table_o, 0);
        start = 1'b0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // 2: constant functions
        sweep("const1", 16'hFFFF, 16'hFFFF, 5'd16, 1'b0);
        @(posedge clk); #1;
        sweep("const0", 16'h0000, 16'h0000, 5'd0, 1'b0);
        @(posedge clk); #1;

        // 3: SETTLE=3 with a lagging result
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n = 1; run_len = 1; hold_bad = 0; prev = vec3;
        while (!done3 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (vec3 == prev) run_len++;
            else begin
                if (run_len != 4) hold_bad++;
                run_len = 1;
                prev = vec3;
            end
        end
        check("settle3_latency", n, 65);
        check("settle3_table", table3, 16'h2C80);
        check("settle3_ones", ones3, 4);
        check("settle3_hold_bad", hold_bad, 0);
        $display("sweep settle3: cycles=%0d table=%h ones=%0d", n, table3, ones3);
        @(posedge clk); #1;

        // 4: start pulses mid-sweep are ignored
        sweep("ignore_start", 16'h2C80, 16'h2C80, 5'd4, 1'b1);

        // 5: reset at vector 9
        fn_tbl = 16'h2C80;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (vec == 4'd9) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_mid_reached9", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_vec", vec, 0);
        check("rst_mid_table", table_o, 0);
        check("rst_mid_done", done, 0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("rst_mid_no_done", n, 0);
        $display("reset at vector 9 applied");
        sweep("after_rst", 16'h2C80, 16'h2C80, 5'd4, 1'b0);

`ifdef EXPECT_CHECK_EN
        // 6: minterm 13 dropped against the expected reference table
        @(posedge clk); #1;
        sweep("expect", 16'h0C80, 16'h0C80, 5'd3, 1'b0);
        check("expect_mismatch", mismatch, 1);
        check("expect_first_bad", first_bad, 13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
